// File: rtl/fft_control_unit_2.sv
// fft_control_unit_2: sequencing controller for an in-place radix-2 DIT FFT.
// It streams sample pairs in to bit-reversed addresses and runs log2(N)
// butterfly stages through a BF_LAT-deep write-back pipe. It then streams
// the results out in natural order under valid/ready.
//
// state  | meaning
// IDLE   | waiting for start_i; mode bits latched on start
// LOAD   | accepting sample pairs, writing to bit-reversed addresses
// COMP   | issuing one butterfly read pair per cycle for the current stage
// DRAIN  | flushing the butterfly pipe for BF_LAT cycles, no reads
// UNLOAD | reading natural-order pairs out under valid/ready
module fft_control_unit_2 #(
   parameter int  N      = 1024,
   parameter int  BF_LAT = 3,
   localparam int L      = $clog2(N),
   localparam int SW     = $clog2(L)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start_i,
   input  logic          inverse_i,
   input  logic          scale_i,
   input  logic          ld_valid_i,
   output logic          ld_ready_o,
   output logic          ul_valid_o,
   input  logic          ul_ready_i,
   output logic [L-1:0]  rd_addr_x0_o,
   output logic [L-1:0]  rd_addr_x1_o,
   output logic          rd_en_o,
   output logic [L-1:0]  wr_addr_x0_o,
   output logic [L-1:0]  wr_addr_x1_o,
   output logic          we_o,
   output logic          src_sel_o,
   output logic          bf_ce_o,
   output logic [L-2:0]  twiddle_addr_o,
   output logic          twiddle_conj_o,
   output logic          bf_scale_o,
   output logic [SW-1:0] stage_o,
   output logic          busy_o,
   output logic          fft_ready_o,
   output logic [2:0]    state_o
);

   localparam int             DW         = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
   localparam int             TWW        = 2 * L - 1;
   localparam logic [DW-1:0]  DRAIN_LOAD = DW'(BF_LAT - 1);
   localparam logic [L-2:0]   LAST       = '1;
   localparam logic [SW-1:0]  LAST_STAGE = SW'(L - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      COMP   = 3'd2,
      DRAIN  = 3'd3,
      UNLOAD = 3'd4
   } state_t;

   state_t        state;
   logic [L-2:0]  cnt;        // load beat, butterfly index or unload read index
   logic [DW-1:0] drain_cnt;
   logic          rd_done;    // last unload read has been issued

   logic [L-1:0]  j_ext;
   logic [L-1:0]  bf_mask;
   logic [L-1:0]  bf_p;
   logic [L-1:0]  bf_a;
   logic [L-1:0]  bf_b;
   logic [L-2:0]  bf_tw;

   logic          pipe_v  [BF_LAT];
   logic [L-1:0]  pipe_a0 [BF_LAT];
   logic [L-1:0]  pipe_a1 [BF_LAT];

   function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
      logic [L-1:0] r;
      for (int i = 0; i < L; i++) r[i] = v[L-1-i];
      return r;
   endfunction

   assign state_o = state;
   assign busy_o  = (state != IDLE);

   // Butterfly pair and twiddle index for butterfly cnt of stage stage_o.
   always_comb begin
      j_ext   = {1'b0, cnt};
      bf_mask = (L'(1) << stage_o) - L'(1);
      bf_p    = j_ext & bf_mask;
      bf_a    = (((j_ext >> stage_o) << 1) << stage_o) | bf_p;
      bf_b    = bf_a | (L'(1) << stage_o);
      bf_tw   = (L-1)'((TWW'(bf_p) << (L - 1)) >> stage_o);
   end

   // RAM/butterfly control. Load writes and write-back come from different
   // states, so they never collide on the write ports.
   always_comb begin
      ld_ready_o     = 1'b0;
      rd_en_o        = 1'b0;
      rd_addr_x0_o   = '0;
      rd_addr_x1_o   = '0;
      wr_addr_x0_o   = '0;
      wr_addr_x1_o   = '0;
      we_o           = 1'b0;
      src_sel_o      = 1'b0;
      bf_ce_o        = 1'b0;
      twiddle_addr_o = '0;
      case (state)
         LOAD: begin
            ld_ready_o   = 1'b1;
            wr_addr_x0_o = bitrev({cnt, 1'b0});
            wr_addr_x1_o = bitrev({cnt, 1'b1});
            we_o         = ld_valid_i;
         end
         COMP: begin
            rd_en_o        = 1'b1;
            rd_addr_x0_o   = bf_a;
            rd_addr_x1_o   = bf_b;
            twiddle_addr_o = bf_tw;
            bf_ce_o        = 1'b1;
            src_sel_o      = 1'b1;
         end
         DRAIN: begin
            bf_ce_o   = 1'b1;
            src_sel_o = 1'b1;
         end
         UNLOAD: begin
            rd_addr_x0_o = {cnt, 1'b0};
            rd_addr_x1_o = {cnt, 1'b1};
            rd_en_o      = ~rd_done & (ul_ready_i | ~ul_valid_o);
         end
         default: ;
      endcase
      if (pipe_v[BF_LAT-1]) begin
         we_o         = 1'b1;
         wr_addr_x0_o = pipe_a0[BF_LAT-1];
         wr_addr_x1_o = pipe_a1[BF_LAT-1];
      end
   end

   // Write-back pipe: read pair re-emerges as the write pair BF_LAT cycles later.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < BF_LAT; i++) begin
            pipe_v[i]  <= 1'b0;
            pipe_a0[i] <= '0;
            pipe_a1[i] <= '0;
         end
      end else begin
         pipe_v[0]  <= (state == COMP);
         pipe_a0[0] <= bf_a;
         pipe_a1[0] <= bf_b;
         for (int i = 1; i < BF_LAT; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_a0[i] <= pipe_a0[i-1];
            pipe_a1[i] <= pipe_a1[i-1];
         end
      end
   end

   // Main sequencer: state, counters, mode latches and unload handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         cnt            <= '0;
         stage_o        <= '0;
         drain_cnt      <= '0;
         rd_done        <= 1'b0;
         ul_valid_o     <= 1'b0;
         fft_ready_o    <= 1'b0;
         twiddle_conj_o <= 1'b0;
         bf_scale_o     <= 1'b0;
      end else begin
         fft_ready_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  twiddle_conj_o <= inverse_i;
                  bf_scale_o     <= scale_i;
                  cnt            <= '0;
                  stage_o        <= '0;
                  state          <= LOAD;
               end
            end
            LOAD: begin
               if (ld_valid_i) begin
                  if (cnt == LAST) begin
                     cnt     <= '0;
                     stage_o <= '0;
                     state   <= COMP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            COMP: begin
               if (cnt == LAST) begin
                  cnt       <= '0;
                  drain_cnt <= DRAIN_LOAD;
                  state     <= DRAIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  if (stage_o == LAST_STAGE) begin
                     state <= UNLOAD;
                  end else begin
                     stage_o <= stage_o + 1'b1;
                     state   <= COMP;
                  end
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            UNLOAD: begin
               if (rd_en_o) begin
                  ul_valid_o <= 1'b1;
                  // Counter parks on the last pair so the address stays put.
                  if (cnt == LAST) rd_done <= 1'b1;
                  else             cnt     <= cnt + 1'b1;
               end else if (ul_ready_i) begin
                  ul_valid_o <= 1'b0;
               end
               if (ul_valid_o && ul_ready_i && rd_done) begin
                  state       <= IDLE;
                  fft_ready_o <= 1'b1;
                  rd_done     <= 1'b0;
                  cnt         <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fft_control_unit_2.md
# fft_control_unit_2

Parametrised sequencing controller for the in-place radix-2 DIT FFT engine. It drives the data-path RAM addresses, the butterfly clock-enable, the twiddle ROM address and the load/unload handshakes for any power-of-two N. Compared with the first-generation controller it adds:

- a valid/ready streaming load and unload;
- a configurable butterfly latency;
- forward/inverse mode;
- optional per-stage 1/2 scaling.

It sits between the FFT top level, the data path (2-read/2-write complex RAM plus butterfly) and the twiddle ROMs.

## Interface
Parameters:
- N, 1024, transform length; power of two, at least 4. L = log2(N), A = L bits.
- BF_LAT, 3, cycles from read-address issue to write-back of the butterfly result (RAM read plus butterfly pipeline); at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- inverse_i  in  1  latched at start; 1 selects IFFT.
- scale_i  in  1  latched at start; 1 requests divide-by-2 in every stage.
- ld_valid_i  in  1  input sample pair valid.
- ld_ready_o  out  1  controller accepts a pair.
- ul_valid_o  out  1  output pair valid, aligned with RAM read data.
- ul_ready_i  in  1  consumer accepts a pair.
- rd_addr_x0_o, rd_addr_x1_o  out  A  read addresses.
- rd_en_o  out  1  RAM read enable; RAM output holds when low.
- wr_addr_x0_o, wr_addr_x1_o  out  A  write addresses.
- we_o  out  1  write enable for both write ports.
- src_sel_o  out  1  write-data mux: 0 = load inputs, 1 = butterfly outputs.
- bf_ce_o  out  1  butterfly pipeline advance.
- twiddle_addr_o  out  L-1  twiddle ROM index.
- twiddle_conj_o  out  1  latched inverse_i.
- bf_scale_o  out  1  latched scale_i.
- stage_o  out  ceil(log2 L)  current stage.
- busy_o  out  1  high in every state except IDLE.
- fft_ready_o  out  1  one-cycle done pulse.
- state_o  out  3  IDLE=0, LOAD=1, COMP=2, DRAIN=3, UNLOAD=4.

## Operation
- Reset: all outputs 0, all counters 0, state IDLE.
- IDLE: on start_i, latch inverse_i and scale_i into twiddle_conj_o and bf_scale_o, then go to LOAD.
- LOAD:
  - ld_ready_o = 1.
  - Beat k (k = 0..N/2-1) is an accepted handshake (ld_valid_i and ld_ready_o); it writes x[2k] to bitrev(2k) and x[2k+1] to bitrev(2k+1).
  - During a beat: wr_addr outputs driven combinationally, we_o = 1, src_sel_o = 0.
  - After beat N/2-1, go to COMP with stage 0.
- COMP, stage s, butterfly j (j = 0..N/2-1, one per cycle):
  - h = 2^s, p = j mod h, a = (j>>s)·2h + p, b = a + h.
  - rd_addr_x0_o = a, rd_addr_x1_o = b, twiddle_addr_o = p << (L-1-s).
  - rd_en_o = bf_ce_o = 1, src_sel_o = 1.
  - After j = N/2-1, go to DRAIN.
- Write-back: the read address pair goes through a BF_LAT-deep shift register with a valid bit. It emerges as wr_addr_x0_o/wr_addr_x1_o with we_o = 1, in place.
- DRAIN:
  - bf_ce_o stays 1 for exactly BF_LAT cycles, flushing the pipe. No reads are issued.
  - Then: if s < L-1, increment s and return to COMP; otherwise go to UNLOAD.
  - Stages never overlap, so there is no read-after-write hazard.
- UNLOAD:
  - Beat k reads natural addresses 2k and 2k+1.
  - rd_en_o = ul_ready_i | ~ul_valid_o. The address counter advances only when rd_en_o = 1.
  - ul_valid_o is set the cycle after an issued read. It holds, with the address and RAM output frozen, while ul_ready_i = 0.
  - After handshake N/2-1, pulse fft_ready_o for one cycle and return to IDLE.
- start_i outside IDLE is ignored.
- rstn low at any point aborts immediately to the reset values. No partial writes occur after reset.

## Timing
- Load: exactly N/2 cycles if ld_valid_i is held high.
- Compute: L·(N/2 + BF_LAT) cycles. Example: N=8, BF_LAT=3 gives 3·(4+3) = 21.
- Unload: N/2 + 1 cycles with ul_ready_i held high; the first ul_valid_o comes one cycle after entering UNLOAD.
- fft_ready_o is asserted the cycle after the last unload handshake. busy_o falls in that same cycle.
- A start_i in the cycle fft_ready_o pulses is accepted, since the state is IDLE.

## Test plan
- Reset mid-COMP: N=8, assert rstn low during stage 1 -> next edge all outputs 0, state_o = 0; a new start_i then runs a full transform.
- Load ordering: N=8, continuous valid -> write-address pairs (0,4),(2,6),(1,5),(3,7); ld_ready_o drops after 4 beats. Stall with ld_valid_i low 2 cycles mid-load -> no write, address held.
- Address/twiddle sequence: N=8, stage 1 -> reads (0,2),(1,3),(4,6),(5,7), twiddles 0,2,0,2. Each write pair appears exactly BF_LAT = 3 cycles after its read pair.
- Compute length: N=8, BF_LAT=3 -> 21 cycles from COMP entry to UNLOAD. N=1024, BF_LAT=5 -> 5170 cycles.
- Unload backpressure: ul_ready_i toggled 1,0,0,1 -> ul_valid_o held, addresses frozen, 4 pairs (0,1),(2,3),(4,5),(6,7) each delivered once; fft_ready_o pulses once.
- Mode latch: start with inverse_i = 1, scale_i = 1, then drop both -> twiddle_conj_o and bf_scale_o stay 1 until the next start; a start_i during LOAD is ignored.
